gate_vector_sequencer: RTL and testbench

Exhaustive truth-table sequencer and checker for a 2-input universal gate under test (switch-level NOR/NAND). On `start` it drives the four input combinations onto the gate and lets each settle for a fixed number of cycles. It then samples the gate output, compares it against a 4-bit expected truth table latched at start, and reports per-vector failures and an overall pass flag. It sits between the gate cells and the self-test/bench harness, replacing free-running toggle stimulus with a clocked, checkable sequence.

---
 rtl/gate_test_pkg.sv | 22 ++
 rtl/gate_settle_timer.sv | 34 +++
 rtl/gate_vector_sequencer.sv | 144 ++++++++++++++
 tb/tb_gate_vector_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate truth-table sequencer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable settle timer: down-counter whose terminal count marks the last settle cycle.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives all four input vectors onto a 2-input gate, samples its output and
// checks it against a truth table latched at start.
//
//   state  | meaning
//   IDLE   | waiting for start; results of last run held
//   SETTLE | current vector driven, waiting for gate output to settle
//   SAMPLE | compare dut_out against latched table bit for current vector
//   DONE   | one-cycle done pulse after results are published
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_tbl,
  input  logic       dut_out,
  output logic       vec_a,
  output logic       vec_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] tbl_q, tbl_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [2:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic       timer_load;
  logic       timer_tc;
  logic       miss;
  logic [3:0] mask_new;

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .tc   (timer_tc)
  );

  assign miss     = (dut_out != tbl_q[idx_q]);
  assign mask_new = mask_q | (4'(miss) << idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    tbl_d       = tbl_q;
    mask_d      = mask_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tbl_d      = truth_tbl;
          idx_d      = 2'd0;
          mask_d     = 4'd0;
          vec_d      = 2'd0;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_tc) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        mask_d = mask_new;
        if (idx_q != LAST_IDX) begin
          idx_d      = idx_q + 2'd1;
          vec_d      = idx_q + 2'd1;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          fail_mask_d = mask_new;
          err_count_d = popcount4(mask_new);
          pass_d      = (mask_new == 4'd0);
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards the in-flight run; published results stay as they were.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      vec_d       = 2'd0;
      timer_load  = 1'b0;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      pass_d      = pass_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      vec_q       <= 2'd0;
      tbl_q       <= 4'd0;
      mask_q      <= 4'd0;
      fail_mask_q <= 4'd0;
      err_count_q <= 3'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      tbl_q       <= tbl_d;
      mask_q      <= mask_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  assign vec_a     = vec_q[0];
  assign vec_b     = vec_q[1];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Self-checking bench: directed and random runs against a truth-table reference model.
module tb_gate_vector_sequencer;
  import gate_test_pkg::*;

  localparam int S0   = 2;
  localparam int PER0 = S0 + 1;
  localparam int RUN0 = 4 * PER0;
  localparam int S1   = 1;
  localparam int PER1 = S1 + 1;
  localparam int RUN1 = 4 * PER1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0;
  logic [3:0] truth_tbl = 4'd0;
  logic [3:0] gate_fn = 4'd0;
  logic       dut_out, vec_a, vec_b, busy, done, pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] truth_tbl1 = 4'd0;
  logic [3:0] gate_fn1 = 4'd0;
  logic       dut_out1, vec_a1, vec_b1, busy1, done1, pass1;
  logic [3:0] fail_mask1;
  logic [2:0] err_count1;

  assign dut_out  = gate_fn[{vec_b, vec_a}];
  assign dut_out1 = gate_fn1[{vec_b1, vec_a1}];

  gate_vector_sequencer #(.SETTLE_CYCLES(S0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .truth_tbl(truth_tbl),
    .dut_out(dut_out), .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .err_count(err_count)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .truth_tbl(truth_tbl1),
    .dut_out(dut_out1), .vec_a(vec_a1), .vec_b(vec_b1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(fail_mask1), .err_count(err_count1)
  );

  int tests = 0;
  int fails = 0;

  // Results of the last completed run as the model sees them.
  logic [3:0] prev_mask = 4'd0;
  logic [2:0] prev_err  = 3'd0;
  logic       prev_pass = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [3:0] m,
                               input logic [2:0] e, input logic p);
    chk({tag, ".fail_mask"}, {4'd0, fail_mask}, {4'd0, m});
    chk({tag, ".err_count"}, {5'd0, err_count}, {5'd0, e});
    chk({tag, ".pass"},      {7'd0, pass},      {7'd0, p});
  endtask

  // Expected results straight from the definition: a vector fails when the
  // gate's actual output differs from the expected table entry.
  task automatic model(input logic [3:0] fn, input logic [3:0] tbl,
                       output logic [3:0] m, output logic [2:0] e, output logic p);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      m[i] = (fn[i] != tbl[i]);
      if (m[i]) n++;
    end
    e = 3'(n);
    p = (n == 0);
  endtask

  task automatic run0(input string tag, input logic [3:0] fn, input logic [3:0] tbl);
    logic [3:0] m;
    logic [2:0] e;
    logic       p;
    model(fn, tbl, m, e, p);
    gate_fn = fn;
    @(negedge clk);
    truth_tbl = tbl;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= RUN0; c++) begin
      if (c > 0) step();
      if (c == 4) begin
        truth_tbl = ~tbl;
        start = 1'b1;
      end
      if (c == 5) start = 1'b0;
      if (c < RUN0) begin
        chk({tag, ".busy"}, {7'd0, busy}, 8'd1);
        chk({tag, ".done"}, {7'd0, done}, 8'd0);
        chk({tag, ".vec"}, {6'd0, vec_b, vec_a}, 8'(c / PER0));
        if (c == RUN0 - 1) check_results({tag, ".held"}, prev_mask, prev_err, prev_pass);
      end else begin
        chk({tag, ".done_pulse"}, {7'd0, done}, 8'd1);
        chk({tag, ".busy_done"}, {7'd0, busy}, 8'd0);
        chk({tag, ".vec_done"}, {6'd0, vec_b, vec_a}, 8'd3);
        check_results(tag, m, e, p);
      end
    end
    prev_mask = m;
    prev_err  = e;
    prev_pass = p;
    step();
    chk({tag, ".idle_done"}, {7'd0, done}, 8'd0);
    chk({tag, ".idle_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, ".idle_vec"}, {6'd0, vec_b, vec_a}, 8'd3);
  endtask

  initial begin
    logic [3:0] rfn, rtbl;

    #12;
    chk("reset.vec",  {6'd0, vec_b, vec_a}, 8'd0);
    chk("reset.busy", {7'd0, busy}, 8'd0);
    chk("reset.done", {7'd0, done}, 8'd0);
    check_results("reset", 4'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run0("nor_nor",   TT_NOR, TT_NOR);
    run0("nor_nand",  TT_NOR, TT_NAND);
    run0("stuck_nor", 4'b0000, TT_NOR);
    run0("nor_again", TT_NOR, TT_NOR);

    // Abort in the second settle cycle of vector 2.
    gate_fn = TT_NOR;
    @(negedge clk);
    truth_tbl = TT_NOR;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 2 * PER0 + 1; c++) step();
    chk("abort.vec_before", {6'd0, vec_b, vec_a}, 8'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.busy", {7'd0, busy}, 8'd0);
    chk("abort.done", {7'd0, done}, 8'd0);
    chk("abort.vec",  {6'd0, vec_b, vec_a}, 8'd0);
    check_results("abort", prev_mask, prev_err, prev_pass);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("abort.no_done", {7'd0, done}, 8'd0);
      chk("abort.idle_vec", {6'd0, vec_b, vec_a}, 8'd0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle.busy", {7'd0, busy}, 8'd0);
    check_results("abort_idle", prev_mask, prev_err, prev_pass);

    for (int r = 0; r < 6; r++) begin
      rfn  = 4'($urandom_range(0, 15));
      rtbl = 4'($urandom_range(0, 15));
      run0($sformatf("rand%0d", r), rfn, rtbl);
    end
    run0("pre_reset", TT_NOR, TT_NAND);

    // Asynchronous reset between clock edges in the middle of a run.
    gate_fn = TT_NOR;
    @(negedge clk);
    truth_tbl = TT_NOR;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= PER0 + 1; c++) step();
    chk("rst.vec_before", {6'd0, vec_b, vec_a}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.vec",  {6'd0, vec_b, vec_a}, 8'd0);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.done", {7'd0, done}, 8'd0);
    check_results("rst", 4'd0, 3'd0, 1'b0);
    prev_mask = 4'd0;
    prev_err  = 3'd0;
    prev_pass = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run0("post_reset", TT_NOR, TT_NOR);

    // SETTLE_CYCLES=1 instance with start held high: back-to-back runs.
    gate_fn1 = TT_NOR;
    @(negedge clk);
    truth_tbl1 = TT_NOR;
    start1 = 1'b1;
    step();
    for (int c = 0; c < 4 * (RUN1 + 2); c++) begin
      int p;
      if (c > 0) step();
      p = c % (RUN1 + 2);
      if (p == 3) truth_tbl1 = TT_AND;
      if (p == 5) truth_tbl1 = TT_NOR;
      if (p < RUN1) begin
        chk("s1.busy", {7'd0, busy1}, 8'd1);
        chk("s1.done", {7'd0, done1}, 8'd0);
        chk("s1.vec",  {6'd0, vec_b1, vec_a1}, 8'(p / PER1));
      end else if (p == RUN1) begin
        chk("s1.done_pulse", {7'd0, done1}, 8'd1);
        chk("s1.pass", {7'd0, pass1}, 8'd1);
        chk("s1.fail_mask", {4'd0, fail_mask1}, 8'd0);
      end else begin
        chk("s1.idle_done", {7'd0, done1}, 8'd0);
        chk("s1.idle_busy", {7'd0, busy1}, 8'd0);
        chk("s1.idle_vec",  {6'd0, vec_b1, vec_a1}, 8'd3);
      end
    end
    start1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
